// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings for the unified byte-wide RAM port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] LS_WORD       = 2'b00;
    localparam logic [1:0] LS_HALF       = 2'b01;
    localparam logic [1:0] LS_BYTE       = 2'b10;
    localparam int         LS_SIGNED_BIT = 2;

    // Size code 2'b11 is treated as a word access.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            LS_HALF: return 3'd2;
            LS_BYTE: return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] st_byte(input logic [31:0] val, input logic [1:0] k);
        return val[{k, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_ld_extend.sv
// ============================================================================
// Module      : ld_extend
// Description : Sign/zero extension of the assembled load word by access size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [2:0]  type_i,
    output logic [31:0] val_o
);

    logic w_sign;

    always_comb begin
        w_sign = 1'b0;
        val_o  = asm_i;
        case (type_i[1:0])
            LS_HALF: begin
                w_sign = type_i[LS_SIGNED_BIT] & asm_i[15];
                val_o  = {{16{w_sign}}, asm_i[15:0]};
            end
            LS_BYTE: begin
                w_sign = type_i[LS_SIGNED_BIT] & asm_i[7];
                val_o  = {{24{w_sign}}, asm_i[7:0]};
            end
            default: val_o = asm_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Single-owner sequencer serialising IF/LSB requests into byte
//               beats on the unified RAM port. Optional macro MEM_IO_STALL_EN
//               holds IO-page write beats while io_buffer_full is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic        ls_r_nw,
    input  logic [2:0]  ls_type,
    input  logic [31:0] ls_st_val,
    output logic        ls_done,
    output logic [31:0] ls_ld_val,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        r_nw_q, r_nw_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] st_val_q, st_val_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        done_q, done_d;

    logic [2:0]  w_cnt_inc;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_next_addr;
    logic        w_hold_grant, w_hold_cur, w_hold_next;
    logic [31:0] w_ld_ext;
    logic        w_if_done;

    assign w_cnt_inc   = cnt_q + 3'd1;
    assign w_cap_idx   = cnt_q[1:0] - 2'd1;
    assign w_next_addr = addr_q + {29'd0, w_cnt_inc};

`ifdef MEM_IO_STALL_EN
    assign w_hold_grant = (ls_addr[17:16] == 2'b11) && io_buffer_full;
    assign w_hold_cur   = (mem_a_q[17:16] == 2'b11) && io_buffer_full;
    assign w_hold_next  = (w_next_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io  = io_buffer_full;
    assign w_hold_grant = 1'b0;
    assign w_hold_cur   = 1'b0;
    assign w_hold_next  = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            r_nw_q     <= 1'b0;
            type_q     <= '0;
            st_val_q   <= '0;
            asm_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            r_nw_q     <= r_nw_d;
            type_q     <= type_d;
            st_val_q   <= st_val_d;
            asm_q      <= asm_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        r_nw_d     = r_nw_q;
        type_d     = type_q;
        st_val_d   = st_val_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        done_d     = 1'b0;

        if (!rdy_in) begin
            done_d = done_q;
            // A paused read is re-issued from its first byte on resume.
            if (state_q == ST_READ) begin
                cnt_d   = '0;
                mem_a_d = addr_q;
                asm_d   = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ls_req) begin
                        owner_d  = OWN_LS;
                        addr_d   = ls_addr;
                        len_d    = beat_count(ls_type[1:0]);
                        r_nw_d   = ls_r_nw;
                        type_d   = ls_type;
                        st_val_d = ls_st_val;
                        cnt_d    = '0;
                        asm_d    = '0;
                        mem_a_d  = ls_addr;
                        if (ls_r_nw) begin
                            state_d = ST_READ;
                        end else begin
                            state_d    = ST_WRITE;
                            mem_dout_d = ls_st_val[7:0];
                            mem_wr_d   = !w_hold_grant;
                        end
                    end else if (if_req && !clear_in) begin
                        owner_d = OWN_IF;
                        addr_d  = if_addr;
                        len_d   = 3'd4;
                        r_nw_d  = 1'b1;
                        type_d  = {1'b0, LS_WORD};
                        cnt_d   = '0;
                        asm_d   = '0;
                        mem_a_d = if_addr;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (owner_q == OWN_IF && clear_in) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            asm_d[{w_cap_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == len_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = w_cnt_inc;
                            if (w_cnt_inc < len_q) begin
                                mem_a_d = w_next_addr;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // mem_wr low here means the current beat is still owed.
                    if (!mem_wr_q) begin
                        mem_dout_d = st_byte(st_val_q, cnt_q[1:0]);
                        mem_wr_d   = !w_hold_cur;
                    end else if (w_cnt_inc == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d      = w_cnt_inc;
                        mem_a_d    = w_next_addr;
                        mem_dout_d = st_byte(st_val_q, w_cnt_inc[1:0]);
                        mem_wr_d   = !w_hold_next;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    ld_extend u_ld_extend (
        .asm_i  (asm_q),
        .type_i (type_q),
        .val_o  (w_ld_ext)
    );

    assign w_if_done = done_q && (owner_q == OWN_IF) && !clear_in;
    assign if_done   = w_if_done;
    assign if_data   = w_if_done ? asm_q : 32'd0;
    assign ls_done   = done_q && (owner_q == OWN_LS);
    assign ls_ld_val = (ls_done && r_nw_q) ? w_ld_ext : 32'd0;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scoreboard bench for mem_arbiter (honours MEM_IO_STALL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_r_nw, ls_done;
    logic [31:0] ls_addr, ls_st_val, ls_ld_val;
    logic [2:0]  ls_type;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    typedef struct { bit is_if; logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

    exp_t     sb_q[$];
    wr_t      wr_q[$];
    bit [7:0] ram [262144];
    int       cyc = 0;
    int       tests = 0;
    int       fails = 0;

    logic [31:0] ld_a   [8] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h1000, 32'h1000, 32'hFFFF_FFFE, 32'h1002};
    logic [2:0]  ld_t   [8] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b000, 3'b011, 3'b100, 3'b110};
    logic [31:0] ld_exp [8] = '{32'h0000_FFFE, 32'hFFFF_FFFE, 32'h0000_0080, 32'hFFFF_FF80,
                                32'h0005_0013, 32'h0005_0013, 32'h2211_BBAA, 32'h0000_0005};

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_r_nw(ls_r_nw), .ls_type(ls_type),
        .ls_st_val(ls_st_val), .ls_done(ls_done), .ls_ld_val(ls_ld_val),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input bit is_if, input string tag);
        int n = 0;
        while (!(is_if ? if_done : ls_done) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(is_if ? if_done : ls_done), 32'd1);
    endtask

    function automatic int len_of(input logic [2:0] t);
        return (t[1:0] == 2'b01) ? 2 : (t[1:0] == 2'b10) ? 1 : 4;
    endfunction

    task automatic ls_op(input logic [31:0] a, input logic [2:0] t, input bit rnw,
                         input logic [31:0] st, input logic [31:0] exp);
        int n = len_of(t);
        sb_q.push_back('{1'b0, exp, cyc + 1 + n + (rnw ? 1 : 0)});
        if (!rnw) begin
            for (int k = 0; k < n; k++) wr_q.push_back('{a + 32'(k), st[8*k +: 8]});
        end
        ls_addr = a; ls_type = t; ls_r_nw = rnw; ls_st_val = st; ls_req = 1'b1;
        wait_done(1'b0, rnw ? "ls_load" : "ls_store");
        ls_req = 1'b0;
        tick();
    endtask

    // Done pulses and write beats are matched in order against the bench's expectations.
    always @(negedge clk_in) begin
        exp_t e;
        wr_t  w;
        if (!rst_in && (if_done || ls_done)) begin
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $error("FAIL done_unexpected: observed if_done=%b ls_done=%b expected none", if_done, ls_done);
            end else begin
                e = sb_q.pop_front();
                check("done_owner_if", 32'(if_done), 32'(e.is_if));
                check("done_owner_ls", 32'(ls_done), 32'(!e.is_if));
                check("done_data", e.is_if ? if_data : ls_ld_val, e.data);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (!rst_in && mem_wr) begin
            if (wr_q.size() == 0) begin
                tests++; fails++;
                $error("FAIL wr_unexpected: observed write %h@%h expected none", mem_dout, mem_a);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", mem_a, w.a);
                check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
            end
        end
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_addr = '0; ls_r_nw = 1'b0;
        ls_type = '0; ls_st_val = '0;
        ram[18'h10] = 8'hFE; ram[18'h11] = 8'hFF; ram[18'h20] = 8'h80;
        ram[18'h1000] = 8'h13; ram[18'h1001] = 8'h00; ram[18'h1002] = 8'h05; ram[18'h1003] = 8'h00;
        ram[18'h2000] = 8'h78; ram[18'h2001] = 8'h56; ram[18'h2002] = 8'h34; ram[18'h2003] = 8'h12;
        ram[18'h3FFFE] = 8'hAA; ram[18'h3FFFF] = 8'hBB; ram[18'h0] = 8'h11; ram[18'h1] = 8'h22;

        repeat (3) tick();
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_ls_done", 32'(ls_done), 32'd0);
        check("rst_ls_ld_val", ls_ld_val, 32'd0);
        rst_in = 1'b0;
        tick();

        // IF word fetch: consecutive byte addresses, done on the 6th cycle
        sb_q.push_back('{1'b1, 32'h0005_0013, cyc + 6});
        if_addr = 32'h1000; if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("if_mem_a", mem_a, 32'h1000 + 32'(k));
        end
        wait_done(1'b1, "if_word");
        if_req = 1'b0;
        tick();

        // Simultaneous requests: LS first, IF after one idle cycle
        sb_q.push_back('{1'b0, 32'hFFFF_FF80, cyc + 3});
        sb_q.push_back('{1'b1, 32'h1234_5678, cyc + 10});
        ls_addr = 32'h20; ls_type = 3'b110; ls_r_nw = 1'b1; ls_req = 1'b1;
        if_addr = 32'h2000; if_req = 1'b1;
        wait_done(1'b0, "prio_ls");
        ls_req = 1'b0;
        wait_done(1'b1, "prio_if");
        if_req = 1'b0;
        tick();

        // Stores, including size code 11 and an address wrap
        ls_op(32'h40, 3'b001, 1'b0, 32'hABCD_1234, 32'd0);
        ls_op(32'h50, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'd0);
        ls_op(32'h60, 3'b010, 1'b0, 32'h0000_0077, 32'd0);
        ls_op(32'h70, 3'b011, 1'b0, 32'h0102_0304, 32'd0);
        ls_op(32'hFFFF_FFFF, 3'b001, 1'b0, 32'h0000_CAFE, 32'd0);

        for (int i = 0; i < 8; i++) ls_op(ld_a[i], ld_t[i], 1'b1, 32'd0, ld_exp[i]);

        // LHU paused for three cycles mid-read restarts from beat 0
        sb_q.push_back('{1'b0, 32'h0000_FFFE, cyc + 8});
        ls_addr = 32'h10; ls_type = 3'b001; ls_r_nw = 1'b1; ls_req = 1'b1;
        tick(); tick();
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pause_ls_done", 32'(ls_done), 32'd0);
        end
        rdy_in = 1'b1;
        wait_done(1'b0, "pause_lhu");
        ls_req = 1'b0;
        tick();

        // Flush at beat 2 aborts IF; the pending LS request is then served
        if_addr = 32'h1000; if_req = 1'b1;
        tick(); tick();
        sb_q.push_back('{1'b0, 32'h0000_0080, cyc + 4});
        clear_in = 1'b1; if_req = 1'b0;
        ls_addr = 32'h20; ls_type = 3'b010; ls_r_nw = 1'b1; ls_req = 1'b1;
        tick();
        check("clr_if_done", 32'(if_done), 32'd0);
        clear_in = 1'b0;
        wait_done(1'b0, "clr_ls");
        ls_req = 1'b0;
        tick();

        // Flush held in IDLE delays the IF grant
        sb_q.push_back('{1'b1, 32'h1234_5678, cyc + 8});
        clear_in = 1'b1; if_addr = 32'h2000; if_req = 1'b1;
        tick(); tick();
        clear_in = 1'b0;
        wait_done(1'b1, "clr_idle_if");
        if_req = 1'b0;
        tick();

        // IO-page byte store with the UART buffer full
        wr_q.push_back('{32'h0003_0000, 8'h5A});
        ls_addr = 32'h0003_0000; ls_type = 3'b010; ls_r_nw = 1'b0; ls_st_val = 32'h5A;
        io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
        sb_q.push_back('{1'b0, 32'd0, cyc + 6});
        ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("io_hold_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
`else
        sb_q.push_back('{1'b0, 32'd0, cyc + 2});
        ls_req = 1'b1;
        tick();
        check("io_ignored_wr", 32'(mem_wr), 32'd1);
`endif
        wait_done(1'b0, "io_store");
        ls_req = 1'b0; io_buffer_full = 1'b0;
        repeat (3) tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("wr_drained", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-owner sequencer for the byte-wide unified RAM port, shared between instruction fetch (IF) and the load/store buffer (LSB). Latches one request at a time, serialises it into 1/2/4 single-byte RAM beats, reassembles and extends load data, and returns a one-cycle done pulse to the requester. Sits between the IF unit, the LSB and the top-level RAM pins.

## Interface
- No parameters.
- `clk_in`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst_in`  in  1  synchronous active-high reset.
- `rdy_in`  in  1  global run enable; low = pause.
- `clear_in`  in  1  branch flush; cancels an in-flight IF read.
- `if_req`  in  1  IF word-read request, level, held until `if_done`.
- `if_addr`  in  32  IF fetch address.
- `if_done`  out  1  one-cycle pulse, `if_data` valid.
- `if_data`  out  32  fetched instruction word.
- `ls_req`  in  1  LSB request (`activate_cache`), level.
- `ls_addr`  in  32  effective address.
- `ls_r_nw`  in  1  1 = load, 0 = store.
- `ls_type`  in  3  [1:0] 00 word / 01 half / 10 byte; [2] 1 = signed.
- `ls_st_val`  in  32  store data, little-endian.
- `ls_done`  out  1  one-cycle pulse.
- `ls_ld_val`  out  32  extended load data, 0 for stores.
- `mem_din`  in  8  RAM read byte, valid the cycle after its address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  1 = write beat.
- `io_buffer_full`  in  1  UART TX full; used only with MEM_IO_STALL_EN.

## Operation
- States: IDLE, READ, WRITE, DONE. Reset: IDLE, all outputs 0, latched request cleared.
- IDLE: sample requests; `ls_req` has fixed priority over `if_req`. Latch owner, address, length n (4/2/1; IF always 4), r_nw, type, store data. Go READ or WRITE with beat counter 0.
- `ls_type[1:0]`=11 treated as word.
- READ: issue mem_a = A+k for k=0..n-1 on consecutive cycles; capture `mem_din` into byte k-1 of a 32-bit assembly register each cycle after the first beat. After byte n-1 captured, go DONE.
- WRITE: mem_wr=1, mem_a=A+k, mem_dout=st_val[8k+7:8k] for k=0..n-1; then DONE.
- DONE: pulse owner's done for exactly one cycle, return to IDLE. No request is sampled in the DONE cycle (prevents regrant of a requester that pops on done).
- Load extension: byte → bits[7:0], half → [15:0], upper bits = sign bit if type[2], else 0. Word unchanged.
- Address arithmetic: 32-bit, wraps modulo 2^32; no alignment check.
- `clear_in` while owner is IF (READ or DONE): abort, no `if_done`, IDLE next cycle. `clear_in` never affects LSB transfers (stores must complete). `clear_in` in IDLE blocks IF grant that cycle.
- `rdy_in` low: all state frozen, mem_wr forced 0. On resume a READ restarts from beat 0 (in-flight capture discarded); a WRITE resumes at the frozen beat (rewriting that byte).
- Address 0 reads/writes are legal; no special treatment besides IO stall.

## Timing
- Request sampled at edge E0. First address on mem_a after E0.
- Read of n bytes: done high in the cycle after edge E0+n+1 (word: 6th cycle after request edge; byte: 3rd).
- Write of n bytes: mem_wr high n cycles after E0; done in cycle after E0+n.
- Back-to-back: next grant at earliest the edge ending the DONE cycle +1 (one IDLE cycle between transfers).
- All outputs registered except `if_data`/`ls_ld_val`, driven from the assembly register and gated by done.

## Configuration
- `MEM_IO_STALL_EN` defined: a WRITE beat with A[17:16]==2'b11 and `io_buffer_full`=1 holds (mem_wr=0, counter frozen) until `io_buffer_full`=0.
- Undefined: `io_buffer_full` ignored; writes never stall.

## Structure
- Shared `macros.v`: ls_type encodings (word/half/byte, signed bit), state encodings, owner encodings (OWN_IF, OWN_LS).
- One sub-module natural: `ld_extend` (combinational 32-bit assembly → sign/zero-extended load value).

## Test plan
- IF word read at 0x1000, RAM bytes 13,00,05,00 → mem_a 0x1000..0x1003 consecutive, `if_done` 6 cycles after request, `if_data`=0x00050013.
- Simultaneous `if_req`/`ls_req` (LB at 0x20, byte 0x80) → LS granted first, `ls_ld_val`=0xFFFFFF80; IF granted after one idle cycle.
- SH 0xABCD1234 at 0x40 → mem_wr 2 cycles, bytes 0x34 @0x40, 0x12 @0x41; `ls_done` next cycle, `ls_ld_val`=0.
- LHU at 0x10 bytes FE,FF → 0x0000FFFE; `rdy_in` low 3 cycles mid-read → restarts, same result.
- `clear_in` at beat 2 of IF read → no `if_done`, IDLE next cycle, pending LS then served.
- With MEM_IO_STALL_EN: SB to 0x30000 while `io_buffer_full`=1 for 4 cycles → mem_wr 0 until release, then one write beat, `ls_done`.
